// File: rtl/stdp_spike_timer.sv
// Pre/post spike timing stage for the STDP weight-change block: pairs nearest-neighbour spikes and emits dt in Q format.
// Optional macro STDP_EVENT_COUNT_EN adds a saturating event_count output.
module stdp_spike_timer #(
  parameter int N      = 32,
  parameter int Q      = 16,
  parameter int AGE_W  = 16,
  parameter int WINDOW = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         pre_spike,
  input  logic         post_spike,
  input  logic         learn_en,
  output logic [N-1:0] t_change,
  output logic         apply
`ifdef STDP_EVENT_COUNT_EN
  ,
  output logic [15:0]  event_count
`endif
);

  localparam logic [AGE_W:0] WIN = (AGE_W+1)'(WINDOW);

  logic             pre_valid, post_valid;
  logic [AGE_W-1:0] pre_age, post_age;
  logic [AGE_W:0]   pre_inc, post_inc;
  logic             pre_keep, post_keep;
  logic             ev_hit;
  logic [N-1:0]     ev_value;

  // age+1 is both the pairing distance and the candidate next age
  assign pre_inc   = {1'b0, pre_age} + {{AGE_W{1'b0}}, 1'b1};
  assign post_inc  = {1'b0, post_age} + {{AGE_W{1'b0}}, 1'b1};
  assign pre_keep  = pre_valid && (pre_inc < WIN);
  assign post_keep = post_valid && (post_inc < WIN);

  always_comb begin
    ev_hit   = 1'b0;
    ev_value = '0;
    if (pre_spike && post_spike) begin
      ev_hit = 1'b1;
    end else if (post_spike && pre_valid) begin
      ev_hit   = 1'b1;
      ev_value = N'(pre_inc) << Q;
    end else if (pre_spike && post_valid) begin
      ev_hit   = 1'b1;
      ev_value = -(N'(post_inc) << Q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_change   <= '0;
      apply      <= 1'b0;
      pre_valid  <= 1'b0;
      post_valid <= 1'b0;
      pre_age    <= '0;
      post_age   <= '0;
    end else begin
      apply <= 1'b0;
      if (tick) begin
        if (ev_hit && learn_en) begin
          apply    <= 1'b1;
          t_change <= ev_value;
        end

        if (pre_spike) begin
          pre_age   <= '0;
          pre_valid <= 1'b1;
        end else if (pre_keep) begin
          pre_age <= pre_inc[AGE_W-1:0];
        end else begin
          pre_valid <= 1'b0;
        end

        if (post_spike) begin
          post_age   <= '0;
          post_valid <= 1'b1;
        end else if (post_keep) begin
          post_age <= post_inc[AGE_W-1:0];
        end else begin
          post_valid <= 1'b0;
        end
      end
    end
  end

`ifdef STDP_EVENT_COUNT_EN
  // Counts the same condition that raises apply, so it moves with each pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      event_count <= '0;
    end else if (tick && ev_hit && learn_en && (event_count != 16'hFFFF)) begin
      event_count <= event_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stdp_spike_timer.sv
// Directed bench for stdp_spike_timer: a tick-indexed spike-time model is compared every cycle, plus literal checks.
// Build with STDP_EVENT_COUNT_EN defined to also check event_count.
module tb_stdp_spike_timer;

  localparam int N      = 32;
  localparam int Q      = 16;
  localparam int AGE_W  = 16;
  localparam int WINDOW = 100;

  logic         clk = 1'b0;
  logic         reset, tick, pre_spike, post_spike, learn_en;
  logic [N-1:0] t_change;
  logic         apply;
`ifdef STDP_EVENT_COUNT_EN
  logic [15:0]  event_count;
`endif

  int total = 0;
  int bad   = 0;

  stdp_spike_timer #(.N(N), .Q(Q), .AGE_W(AGE_W), .WINDOW(WINDOW)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .pre_spike(pre_spike),
    .post_spike(post_spike),
    .learn_en(learn_en),
    .t_change(t_change),
    .apply(apply)
`ifdef STDP_EVENT_COUNT_EN
    ,
    .event_count(event_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: remember the tick index of the last spike on each side; a pair exists
  // when the opposite spike is at most WINDOW ticks old.
  int           tick_no = 0;
  int           pre_last, post_last;
  logic         exp_apply;
  logic [N-1:0] exp_t;
  int           exp_cnt;
  bit           model_ready = 0;

  always @(posedge clk) begin
    int  dt;
    bit  have_ev;
    if (reset) begin
      pre_last    = -1;
      post_last   = -1;
      exp_apply   = 1'b0;
      exp_t       = '0;
      exp_cnt     = 0;
      model_ready = 1;
    end else if (model_ready) begin
      exp_apply = 1'b0;
      if (tick) begin
        have_ev = 0;
        dt      = 0;
        if (pre_spike && post_spike) begin
          have_ev = 1;
        end else if (post_spike && pre_last >= 0 && (tick_no - pre_last) <= WINDOW) begin
          have_ev = 1;
          dt      = tick_no - pre_last;
        end else if (pre_spike && post_last >= 0 && (tick_no - post_last) <= WINDOW) begin
          have_ev = 1;
          dt      = -(tick_no - post_last);
        end
        if (have_ev && learn_en) begin
          exp_apply = 1'b1;
          exp_t     = N'(dt * (1 << Q));
          if (exp_cnt < 65535) exp_cnt++;
        end
        if (pre_spike) pre_last = tick_no;
        if (post_spike) post_last = tick_no;
        tick_no++;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ready && !reset) begin
      total++;
      if (apply !== exp_apply) begin
        bad++;
        $display("[TB] FAIL cycle_apply t=%0t: got %0b want %0b", $time, apply, exp_apply);
      end
      total++;
      if (t_change !== exp_t) begin
        bad++;
        $display("[TB] FAIL cycle_t_change t=%0t: got %08h want %08h", $time, t_change, exp_t);
      end
`ifdef STDP_EVENT_COUNT_EN
      total++;
      if (event_count !== 16'(exp_cnt)) begin
        bad++;
        $display("[TB] FAIL cycle_event_count t=%0t: got %0d want %0d", $time, event_count, exp_cnt);
      end
`endif
    end
  end

  // One tick cycle with the given spikes; returns #1 after the edge, when apply is visible
  task automatic applyStimulus(input logic pre, input logic post);
    tick       = 1'b1;
    pre_spike  = pre;
    post_spike = post;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    repeat (n) @(posedge clk);
    #1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic want_apply, input logic [N-1:0] want_t);
    total++;
    if (apply !== want_apply) begin
      bad++;
      $display("[TB] FAIL %s apply: got %0b want %0b", name, apply, want_apply);
    end
    total++;
    if (t_change !== want_t) begin
      bad++;
      $display("[TB] FAIL %s t_change: got %08h want %08h", name, t_change, want_t);
    end
  endtask

  initial begin
    reset      = 1'b1;
    tick       = 1'b0;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
    learn_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", 1'b0, 32'h0);

    // pre on tick 0, post on tick 3; spike lines high on non-tick cycles are ignored
    applyStimulus(1, 0);
    idleCycles(2, 1, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("pre_then_post", 1'b1, 32'h00030000);
    idleCycles(1, 0, 0);
    checkOutput("apply_clears", 1'b0, 32'h00030000);

    // post on tick 0, pre on tick 5
    doReset();
    applyStimulus(0, 1);
    repeat (4) applyStimulus(0, 0);
    applyStimulus(1, 0);
    checkOutput("post_then_pre", 1'b1, 32'hFFFB0000);

    // continue without reset: earlier pre on tick 2, both on tick 7
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (4) applyStimulus(0, 0);
    applyStimulus(1, 1);
    checkOutput("simultaneous", 1'b1, 32'h00000000);
    idleCycles(1, 0, 0);
    checkOutput("simultaneous_single", 1'b0, 32'h00000000);

    // window edge: dt=100 pairs
    doReset();
    applyStimulus(1, 0);
    repeat (99) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("window_edge", 1'b1, 32'h00640000);

    // dt=101 does not pair; the expired pre stays invalid for a later post too
    doReset();
    applyStimulus(1, 0);
    repeat (100) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("window_past", 1'b0, 32'h0);
    applyStimulus(0, 1);
    checkOutput("pre_expired", 1'b0, 32'h0);
    applyStimulus(1, 0);
    checkOutput("post_then_pre_1", 1'b1, 32'hFFFF0000);

    // reset between tick 1 and 2 clears the pre; a tick+pre in the reset cycle is dropped
    doReset();
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    reset     = 1'b1;
    tick      = 1'b1;
    pre_spike = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    tick      = 1'b0;
    pre_spike = 1'b0;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("reset_mid", 1'b0, 32'h0);

    // learn_en gating
    doReset();
    learn_en = 1'b0;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("learn_off", 1'b0, 32'h0);
    learn_en = 1'b1;
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("learn_on", 1'b1, 32'h00040000);
`ifdef STDP_EVENT_COUNT_EN
    total++;
    if (event_count !== 16'd1) begin
      bad++;
      $display("[TB] FAIL learn_count event_count: got %0d want 1", event_count);
    end
`endif

    // back-to-back ticks produce consecutive applies
    doReset();
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    checkOutput("b2b_1", 1'b1, 32'h00010000);
    applyStimulus(1, 0);
    checkOutput("b2b_2", 1'b1, 32'hFFFF0000);
    applyStimulus(0, 1);
    checkOutput("b2b_3", 1'b1, 32'h00010000);
    idleCycles(3, 0, 0);
    checkOutput("b2b_idle", 1'b0, 32'h00010000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
